splitter_byte_sequencer: RTL and testbench
==========================================

// Module: splitter_byte_sequencer
// PURPOSE
//  Sequences 32-bit words through the byte splitter path: accepts one word per
//  valid/ready handshake and emits its selected bytes one per cycle on a byte
//  stream. Byte lane 0 = A[31:24], lane 1 = A[23:16], lane 2 = A[15:8], lane 3 = A[7:0].
//  Sits between a word producer and a byte-wide consumer; a 1-entry hold register
//  decouples input from the serialiser so words can stream back-to-back.
// PARAMETERS
//  MSB_FIRST  1  1: emit pending lanes in order 0->3; 0: emit in order 3->0
//  CNT_W      8  width of words_done counter
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      producer has a word
//  in_ready    out  1      block can accept a word (= !hold_valid)
//  in_word     in   32     word to serialise
//  in_bmask    in   4      lane enables, bit i = lane i; 0 lanes skipped
//  out_valid   out  1      out_byte valid
//  out_ready   in   1      consumer accepts byte
//  out_byte    out  8      current byte
//  out_idx     out  2      lane index of out_byte
//  out_last    out  1      current byte is last pending lane of its word
//  busy        out  1      hold or shift register occupied
//  words_done  out  CNT_W  count of words fully emitted (wraps)
// BEHAVIOUR
//  - Reset (rst_n=0, async): hold/shift regs empty; in_ready=1, out_valid=0,
//    out_byte=0, out_idx=0, out_last=0, busy=0, words_done=0. In-flight data dropped.
//  - Input accept: in_valid&&in_ready at edge -> hold={in_word,in_bmask}, hold_valid=1.
//  - Shift states: IDLE (shift empty), EMIT (shift holds word + pending mask).
//  - Transfer hold->shift when hold_valid and (IDLE or final byte accepted this cycle:
//    out_valid&&out_ready&&out_last). hold_valid clears; in_ready rises next cycle.
//  - Transfer with bmask=0: word discarded, shift stays/becomes IDLE, not counted.
//  - EMIT: out_valid=1; out_idx = first pending lane in emit order; out_byte = that
//    lane; out_last = no other pending lane. On out_ready, clear that lane bit; if it
//    was last -> words_done+1 and go IDLE (or load hold same edge).
//  - out_byte/out_idx/out_last held stable while out_valid&&!out_ready.
//  - Latency: accept at edge k -> out_valid at edge k+1 (hold->shift if IDLE).
//    Steady-state throughput with full masks: 4 bytes/word, no bubble between words.
//  - Simultaneous: accept into hold and hold->shift never same edge (in_ready
//    registered from hold_valid); hold->shift and final-byte accept same edge allowed.
//  - words_done wraps 2^CNT_W-1 -> 0.
//  - busy = hold_valid | (state==EMIT).
// TESTING
//  1. word 0xA1B2C3D4, mask 4'hF, out_ready=1 -> bytes A1,B2,C3,D4, idx 0..3, last on D4, words_done=1
//  2. MSB_FIRST=0, same word -> D4,C3,B2,A1, idx 3..0
//  3. mask 4'b0101 on 0x11223344 -> 11 (idx0), 33 (idx2, last); mask 0 word -> no output, count unchanged
//  4. 3 words back-to-back, out_ready=1 -> 12 bytes on 12 consecutive cycles after first; out_ready toggled -> byte stable while stalled
//  5. rst_n low mid-word (after 2 bytes) -> out_valid=0, in_ready=1, words_done=0 immediately; next word emits fully
//  6. 2^CNT_W+1 words -> words_done wraps to 1

Source files
------------

// File: rtl/splitter_byte_sequencer.sv
// Word-to-byte serialiser: a 1-entry hold register feeds a shift register that
// emits the enabled byte lanes of each 32-bit word, one per handshake.
module splitter_byte_sequencer #(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  input  logic [3:0]       in_bmask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_d;
  logic        hold_valid;
  logic [31:0] hold_word;
  logic [3:0]  hold_mask;
  logic [31:0] shift_word, shift_word_d;
  logic [3:0]  shift_mask, shift_mask_d;
  logic [1:0]  sel_idx;
  logic [3:0]  sel_oh;
  logic [7:0]  lane_byte;
  logic        accept, fire, done, load;

  // Pick the first pending lane in emit order; the last write in the loop wins.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (MSB_FIRST != 0) begin
        if (shift_mask[3-i]) sel_idx = 2'(3-i);
      end else begin
        if (shift_mask[i]) sel_idx = 2'(i);
      end
    end
    sel_oh = 4'b0001 << sel_idx;
    case (sel_idx)
      2'd0:    lane_byte = shift_word[31:24];
      2'd1:    lane_byte = shift_word[23:16];
      2'd2:    lane_byte = shift_word[15:8];
      default: lane_byte = shift_word[7:0];
    endcase
  end

  // State register plus the hold/shift datapath and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_word <= '0;
      shift_mask <= '0;
      hold_valid <= 1'b0;
      hold_word  <= '0;
      hold_mask  <= '0;
      words_done <= '0;
    end else begin
      state      <= state_d;
      shift_word <= shift_word_d;
      shift_mask <= shift_mask_d;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_word  <= in_word;
        hold_mask  <= in_bmask;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
      if (done) words_done <= words_done + CNT_W'(1);
    end
  end

  // Next state: a hold->shift load may coincide with the final byte leaving.
  always_comb begin
    accept       = in_valid && !hold_valid;
    fire         = out_valid && out_ready;
    done         = fire && out_last;
    load         = hold_valid && (state == IDLE || done);
    state_d      = state;
    shift_word_d = shift_word;
    shift_mask_d = shift_mask;
    if (fire) shift_mask_d = shift_mask & ~sel_oh;
    if (done) state_d = IDLE;
    if (load) begin
      shift_word_d = hold_word;
      shift_mask_d = hold_mask;
      state_d      = (hold_mask != '0) ? EMIT : IDLE;
    end
  end

  always_comb begin
    in_ready  = !hold_valid;
    busy      = hold_valid || (state == EMIT);
    out_valid = (state == EMIT);
    out_byte  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (state == EMIT) begin
      out_byte = lane_byte;
      out_idx  = sel_idx;
      out_last = (shift_mask & ~sel_oh) == '0;
    end
  end

endmodule

// File: tb/tb_splitter_byte_sequencer.sv
// Directed bench: two instances (MSB-first and LSB-first) share the input stream.
module tb_splitter_byte_sequencer;

  typedef struct {
    logic [1:0]  idx;
    logic        last;
    logic [7:0]  b;
    int unsigned cyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] in_word;
  logic [3:0]  in_bmask;
  logic        a_in_ready, a_valid, a_last, a_busy;
  logic        b_in_ready, b_valid, b_last, b_busy;
  logic [7:0]  a_byte, b_byte, a_done, b_done;
  logic [1:0]  a_idx, b_idx;

  int unsigned total = 0, bad = 0, cyc = 0;
  ent_t qa[$], qb[$];

  splitter_byte_sequencer #(.MSB_FIRST(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_word(in_word), .in_bmask(in_bmask), .out_valid(a_valid), .out_ready(out_ready),
    .out_byte(a_byte), .out_idx(a_idx), .out_last(a_last), .busy(a_busy),
    .words_done(a_done));

  splitter_byte_sequencer #(.MSB_FIRST(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_word(in_word), .in_bmask(in_bmask), .out_valid(b_valid), .out_ready(out_ready),
    .out_byte(b_byte), .out_idx(b_idx), .out_last(b_last), .busy(b_busy),
    .words_done(b_done));

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && out_ready) begin
      if (a_valid) qa.push_back('{a_idx, a_last, a_byte, cyc});
      if (b_valid) qb.push_back('{b_idx, b_last, b_byte, cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] w, input logic [3:0] m);
    int unsigned n = 0;
    while (!a_in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("put_timeout", 1, 0);
    in_valid = 1'b1; in_word = w; in_bmask = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((a_busy || b_busy) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_ent(input string tag, input ent_t e, input logic [1:0] idx,
                         input logic last, input logic [7:0] b);
    chk(tag, {21'b0, e.idx, e.last, e.b}, {21'b0, idx, last, b});
  endtask

  initial begin
    logic [31:0] w;
    int unsigned n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_word = '0; in_bmask = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 32'(a_in_ready), 1);
    chk("rst_out_valid", 32'(a_valid), 0);
    chk("rst_out_byte", 32'(a_byte), 0);
    chk("rst_out_idx", 32'(a_idx), 0);
    chk("rst_out_last", 32'(a_last), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_words_done", 32'(a_done), 0);

    // Full word, both emit orders, plus one-cycle latency.
    w = 32'hA1B2C3D4;
    qa.delete(); qb.delete();
    put(w, 4'hF);
    chk("lat_hold_valid", 32'(a_valid), 0);
    chk("lat_hold_ready", 32'(a_in_ready), 0);
    chk("lat_hold_busy", 32'(a_busy), 1);
    @(posedge clk); #1;
    chk("lat_out_valid", 32'(a_valid), 1);
    chk("lat_out_byte", 32'(a_byte), 32'hA1);
    chk("lat_in_ready", 32'(a_in_ready), 1);
    wait_idle();
    chk("t1_count", qa.size(), 4);
    chk("t2_count", qb.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < qa.size()) chk_ent("t1_byte", qa[i], 2'(i), i == 3, w[31-8*i -: 8]);
      if (i < qb.size()) chk_ent("t2_byte", qb[i], 2'(3-i), i == 3, w[8*i +: 8]);
    end
    chk("t1_words_done", 32'(a_done), 1);
    chk("t2_words_done", 32'(b_done), 1);

    // Sparse mask, then an all-zero mask that must vanish.
    qa.delete(); qb.delete();
    put(32'h11223344, 4'b0101);
    wait_idle();
    chk("t3_count", qa.size(), 2);
    if (qa.size() >= 2) begin
      chk_ent("t3_lane0", qa[0], 2'd0, 1'b0, 8'h11);
      chk_ent("t3_lane2", qa[1], 2'd2, 1'b1, 8'h33);
    end
    chk("t3_words_done", 32'(a_done), 2);
    qa.delete();
    put(32'h55667788, 4'b0000);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("t3_zero_count", qa.size(), 0);
    chk("t3_zero_words_done", 32'(a_done), 2);

    // Back-to-back words: 12 bytes on consecutive cycles.
    qa.delete(); qb.delete();
    put(32'h01020304, 4'hF);
    put(32'h05060708, 4'hF);
    put(32'h090A0B0C, 4'hF);
    wait_idle();
    chk("t4_count", qa.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < qa.size()) begin
        chk_ent("t4_byte", qa[i], 2'(i % 4), (i % 4) == 3, 8'(i + 1));
        chk("t4_cycle", qa[i].cyc, qa[0].cyc + 32'(i));
      end
    end
    chk("t4_words_done", 32'(a_done), 5);

    // Stall: output must hold while out_ready is low.
    out_ready = 1'b0;
    put(32'h55667788, 4'hF);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(a_valid), 1);
      chk("stall_byte", 32'(a_byte), 32'h55);
      chk("stall_idx", 32'(a_idx), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_next_byte", 32'(a_byte), 32'h66);
    chk("stall_next_idx", 32'(a_idx), 1);
    @(posedge clk); #1;
    chk("stall_hold_again", 32'(a_byte), 32'h66);
    out_ready = 1'b1;
    wait_idle();
    chk("stall_words_done", 32'(a_done), 6);

    // Reset in the middle of a word.
    qa.delete(); qb.delete();
    put(32'hDEADBEEF, 4'hF);
    n = 0;
    while (qa.size() < 2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_two_bytes", qa.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(a_valid), 0);
    chk("t5_in_ready", 32'(a_in_ready), 1);
    chk("t5_words_done", 32'(a_done), 0);
    chk("t5_busy", 32'(a_busy), 0);
    #3 rst_n = 1'b1;
    qa.delete(); qb.delete();
    w = 32'hCAFEF00D;
    put(w, 4'hF);
    wait_idle();
    chk("t5_count", qa.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < qa.size()) chk_ent("t5_byte", qa[i], 2'(i), i == 3, w[31-8*i -: 8]);
    chk("t5_words_after", 32'(a_done), 1);

    // Counter wrap: 256 words since reset -> 0, one more -> 1.
    for (int i = 0; i < 255; i++) put(32'(i), 4'h1);
    wait_idle();
    chk("t6_wrap_zero", 32'(a_done), 0);
    put(32'h0, 4'h8);
    wait_idle();
    chk("t6_wrap_one", 32'(a_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
